// File: rtl/ex_seq_pkg.sv
// Shared op codes and widths for the EX-stage sequencer.
package ex_seq_pkg;

  localparam int unsigned DW_DEF  = 32;
  localparam int unsigned AW_DEF  = 5;
  localparam int unsigned OPW_DEF = 8;
  localparam int unsigned FW_DEF  = 3;

  localparam logic [7:0] EXE_ORI = 8'h13;
  localparam logic [7:0] EXE_OR  = 8'h33;

  localparam logic [2:0] FUN_ADD  = 3'b000;
  localparam logic [2:0] FUN_SLLI = 3'b001;
  localparam logic [2:0] FUN_SLL  = 3'b001;
  localparam logic [2:0] FUN_SRLI = 3'b101;
  localparam logic [2:0] FUN_SRL  = 3'b101;
  localparam logic [2:0] FUN_OR   = 3'b110;
  localparam logic [2:0] FUN_ORI  = 3'b110;

  // imm bit that selects arithmetic right shift / subtract
  localparam int unsigned IMM_ARITH_BIT = 10;

endpackage

// File: rtl/ex_shift_iter.sv
// Iterative 1-bit/cycle shifter: accumulator, remaining count and latched direction/fill.
module ex_shift_iter
  import ex_seq_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   clear_i,
  input  logic                   step_i,
  input  logic [DW-1:0]          val_i,
  input  logic [$clog2(DW)-1:0]  cnt_i,
  input  logic                   right_i,
  input  logic                   arith_i,
  output logic [DW-1:0]          acc_o,
  output logic                   last_o
);

  localparam int unsigned CW = $clog2(DW);

  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          right_q, right_d;
  logic          arith_q, arith_d;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    arith_d = arith_q;
    if (clear_i) begin
      acc_d   = '0;
      cnt_d   = '0;
      right_d = 1'b0;
      arith_d = 1'b0;
    end else if (load_i) begin
      acc_d   = val_i;
      cnt_d   = cnt_i;
      right_d = right_i;
      arith_d = arith_i;
    end else if (step_i && (cnt_q != '0)) begin
      acc_d = right_q ? {arith_q & acc_q[DW-1], acc_q[DW-1:1]}
                      : {acc_q[DW-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
      arith_q <= arith_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/ex_seq.sv
// EX-stage sequencer: operand register feeding the external ALU, iterative
// shifts, and an EX/MEM output register with backpressure and flush.
module ex_seq
  import ex_seq_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned OPW = OPW_DEF,
  parameter int unsigned FW  = FW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid_i,
  output logic           id_ready_o,
  input  logic [OPW-1:0] aluop_i,
  input  logic [FW-1:0]  alufun_i,
  input  logic [DW-1:0]  reg1_i,
  input  logic [DW-1:0]  reg2_i,
  input  logic [DW-1:0]  imm_i,
  input  logic [AW-1:0]  wd_i,
  input  logic           wreg_i,
  input  logic           flush_i,
  output logic [OPW-1:0] alu_aluop_o,
  output logic [FW-1:0]  alu_alufun_o,
  output logic [DW-1:0]  alu_reg1_o,
  output logic [DW-1:0]  alu_reg2_o,
  output logic [DW-1:0]  alu_imm_o,
  output logic [AW-1:0]  alu_wd_o,
  output logic           alu_wreg_o,
  input  logic [DW-1:0]  alu_wdata_i,
  output logic           mem_valid_o,
  input  logic           mem_ready_i,
  output logic [AW-1:0]  wd_o,
  output logic           wreg_o,
  output logic [DW-1:0]  wdata_o,
  output logic           busy_o
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] aluop_q, aluop_d;
  logic [FW-1:0]  alufun_q, alufun_d;
  logic [DW-1:0]  reg1_q, reg1_d;
  logic [DW-1:0]  reg2_q, reg2_d;
  logic [DW-1:0]  imm_q, imm_d;
  logic [AW-1:0]  wd_q, wd_d;
  logic           wreg_q, wreg_d;
  logic           from_shift_q, from_shift_d;
  logic           mem_valid_q, mem_valid_d;
  logic [AW-1:0]  wd_out_q, wd_out_d;
  logic           wreg_out_q, wreg_out_d;
  logic [DW-1:0]  wdata_out_q, wdata_out_d;

  logic           out_free, id_ready, accept, capture;
  logic           op_load, op_clear, sh_load, sh_clear, sh_step, sh_last;
  logic           dec_shift, dec_right;
  logic [CW-1:0]  dec_shamt;
  logic [DW-1:0]  sh_acc, result;

  always_comb begin
    dec_shift = 1'b0;
    dec_right = 1'b0;
    dec_shamt = '0;
    if (aluop_i == OPW'(EXE_ORI) &&
        (alufun_i == FW'(FUN_SLLI) || alufun_i == FW'(FUN_SRLI))) begin
      dec_shift = 1'b1;
      dec_right = (alufun_i == FW'(FUN_SRLI));
      dec_shamt = imm_i[CW-1:0];
    end else if (aluop_i == OPW'(EXE_OR) &&
                 (alufun_i == FW'(FUN_SLL) || alufun_i == FW'(FUN_SRL))) begin
      dec_shift = 1'b1;
      dec_right = (alufun_i == FW'(FUN_SRL));
      dec_shamt = reg2_i[CW-1:0];
    end
  end

  ex_shift_iter #(.DW(DW)) u_shift (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (sh_load),
    .clear_i (sh_clear),
    .step_i  (sh_step),
    .val_i   (reg1_i),
    .cnt_i   (dec_shamt),
    .right_i (dec_right),
    .arith_i (imm_i[IMM_ARITH_BIT]),
    .acc_o   (sh_acc),
    .last_o  (sh_last)
  );

  assign out_free = !mem_valid_q || mem_ready_i;
  assign result   = from_shift_q ? sh_acc : alu_wdata_i;

  // flush overrides the per-state decisions; accept is resolved after so a
  // flushed cycle can never load a new op.
  always_comb begin
    state_d      = state_q;
    from_shift_d = from_shift_q;
    id_ready     = 1'b0;
    capture      = 1'b0;
    accept       = 1'b0;
    op_load      = 1'b0;
    op_clear     = 1'b0;
    sh_load      = 1'b0;
    sh_clear     = 1'b0;
    sh_step      = 1'b0;
    unique case (state_q)
      IDLE: id_ready = 1'b1;
      EXEC: begin
        id_ready = out_free;
        capture  = out_free;
      end
      SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) begin
          state_d      = EXEC;
          from_shift_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      id_ready     = 1'b0;
      capture      = 1'b0;
      sh_step      = 1'b0;
      sh_clear     = 1'b1;
      op_clear     = 1'b1;
      from_shift_d = 1'b0;
      state_d      = IDLE;
    end
    accept = id_valid_i && id_ready;
    if (accept) begin
      op_load      = 1'b1;
      from_shift_d = 1'b0;
      if (dec_shift && (dec_shamt != '0)) begin
        sh_load = 1'b1;
        state_d = SHIFT;
      end else begin
        state_d = EXEC;
      end
    end else if (capture) begin
      op_clear     = 1'b1;
      from_shift_d = 1'b0;
      state_d      = IDLE;
    end
  end

  always_comb begin
    aluop_d  = aluop_q;
    alufun_d = alufun_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;
    imm_d    = imm_q;
    wd_d     = wd_q;
    wreg_d   = wreg_q;
    if (op_load) begin
      aluop_d  = aluop_i;
      alufun_d = alufun_i;
      reg1_d   = reg1_i;
      reg2_d   = reg2_i;
      imm_d    = imm_i;
      wd_d     = wd_i;
      wreg_d   = wreg_i;
    end else if (op_clear) begin
      aluop_d  = '0;
      alufun_d = '0;
      reg1_d   = '0;
      reg2_d   = '0;
      imm_d    = '0;
      wd_d     = '0;
      wreg_d   = 1'b0;
    end
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    wd_out_d    = wd_out_q;
    wreg_out_d  = wreg_out_q;
    wdata_out_d = wdata_out_q;
    if (capture) begin
      mem_valid_d = 1'b1;
      wd_out_d    = wd_q;
      wreg_out_d  = wreg_q;
      wdata_out_d = result;
    end else if (mem_ready_i) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      aluop_q      <= '0;
      alufun_q     <= '0;
      reg1_q       <= '0;
      reg2_q       <= '0;
      imm_q        <= '0;
      wd_q         <= '0;
      wreg_q       <= 1'b0;
      from_shift_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      wd_out_q     <= '0;
      wreg_out_q   <= 1'b0;
      wdata_out_q  <= '0;
    end else begin
      state_q      <= state_d;
      aluop_q      <= aluop_d;
      alufun_q     <= alufun_d;
      reg1_q       <= reg1_d;
      reg2_q       <= reg2_d;
      imm_q        <= imm_d;
      wd_q         <= wd_d;
      wreg_q       <= wreg_d;
      from_shift_q <= from_shift_d;
      mem_valid_q  <= mem_valid_d;
      wd_out_q     <= wd_out_d;
      wreg_out_q   <= wreg_out_d;
      wdata_out_q  <= wdata_out_d;
    end
  end

  assign id_ready_o   = id_ready && rst;
  assign busy_o       = (state_q != IDLE);
  assign alu_aluop_o  = aluop_q;
  assign alu_alufun_o = alufun_q;
  assign alu_reg1_o   = reg1_q;
  assign alu_reg2_o   = reg2_q;
  assign alu_imm_o    = imm_q;
  assign alu_wd_o     = wd_q;
  assign alu_wreg_o   = wreg_q;
  assign mem_valid_o  = mem_valid_q;
  assign wd_o         = wd_out_q;
  assign wreg_o       = wreg_out_q;
  assign wdata_o      = wdata_out_q;

endmodule

// File: tb/tb_ex_seq.sv
// Directed bench for ex_seq with a small stand-in ALU on the alu_* operand bus.
module tb_ex_seq;
  import ex_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, id_ready_o;
  logic [7:0]  aluop_i;
  logic [2:0]  alufun_i;
  logic [31:0] reg1_i, reg2_i, imm_i;
  logic [4:0]  wd_i;
  logic        wreg_i, flush_i;
  logic [7:0]  alu_aluop_o;
  logic [2:0]  alu_alufun_o;
  logic [31:0] alu_reg1_o, alu_reg2_o, alu_imm_o;
  logic [4:0]  alu_wd_o;
  logic        alu_wreg_o;
  logic [31:0] alu_wdata_i;
  logic        mem_valid_o, mem_ready_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        busy_o;

  always #5 clk = ~clk;

  ex_seq #(.DW(32), .AW(5), .OPW(8), .FW(3)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .aluop_i(aluop_i), .alufun_i(alufun_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .imm_i(imm_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
    .alu_aluop_o(alu_aluop_o), .alu_alufun_o(alu_alufun_o),
    .alu_reg1_o(alu_reg1_o), .alu_reg2_o(alu_reg2_o), .alu_imm_o(alu_imm_o),
    .alu_wd_o(alu_wd_o), .alu_wreg_o(alu_wreg_o), .alu_wdata_i(alu_wdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .busy_o(busy_o)
  );

  // Stand-in combinational ALU; unknown op classes return reg1 ^ reg2.
  always_comb begin
    logic [4:0] sh;
    alu_wdata_i = alu_reg1_o ^ alu_reg2_o;
    sh = (alu_aluop_o == EXE_ORI) ? alu_imm_o[4:0] : alu_reg2_o[4:0];
    if (alu_aluop_o == EXE_ORI || alu_aluop_o == EXE_OR) begin
      case (alu_alufun_o)
        FUN_ADD: alu_wdata_i = (alu_aluop_o == EXE_OR && alu_imm_o[10])
                               ? alu_reg1_o - alu_reg2_o
                               : alu_reg1_o + ((alu_aluop_o == EXE_ORI) ? alu_imm_o : alu_reg2_o);
        FUN_OR:  alu_wdata_i = alu_reg1_o | ((alu_aluop_o == EXE_ORI) ? alu_imm_o : alu_reg2_o);
        FUN_SLL: alu_wdata_i = alu_reg1_o << sh;
        FUN_SRL: alu_wdata_i = alu_imm_o[10] ? 32'($signed(alu_reg1_o) >>> sh) : alu_reg1_o >> sh;
        default: alu_wdata_i = '0;
      endcase
    end
  end

  logic [31:0] got[$];
  always @(negedge clk) if (rst && mem_valid_o && mem_ready_i) got.push_back(wdata_o);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [7:0] op, input logic [2:0] fn, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] im, input logic [4:0] wd);
    aluop_i = op; alufun_i = fn; reg1_i = r1; reg2_i = r2; imm_i = im; wd_i = wd; wreg_i = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  fun;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] imm;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic run_op(input vec_t v, input int idx);
    int n;
    n = 0;
    while (!id_ready_o && n < 50) begin @(posedge clk); #1; n++; end
    drive_op(v.aluop, v.fun, v.reg1, v.reg2, v.imm, 5'(idx + 1));
    id_valid_i = 1'b1;
    @(posedge clk); #1;
    id_valid_i = 1'b0;
    chk($sformatf("busy_after_accept[%0d]", idx), 32'(busy_o), 32'd1);
    chk($sformatf("id_ready_after_accept[%0d]", idx), 32'(id_ready_o), (v.lat == 1) ? 32'd1 : 32'd0);
    n = 0;
    while (!mem_valid_o && n < 40) begin @(posedge clk); #1; n++; end
    chk($sformatf("latency[%0d]", idx), 32'(n), 32'(v.lat));
    chk($sformatf("wdata[%0d]", idx), wdata_o, v.exp);
    chk($sformatf("wd[%0d]", idx), 32'(wd_o), 32'(idx + 1));
    chk($sformatf("wreg[%0d]", idx), 32'(wreg_o), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{EXE_ORI, FUN_ORI, 32'h0000_00F0, 32'h0,          32'h0000_000F, 32'h0000_00FF, 1};
    vecs[1]  = '{EXE_OR,  FUN_ADD, 32'd5,         32'd7,          32'h0,         32'd12,        1};
    vecs[2]  = '{EXE_OR,  FUN_ADD, 32'd10,        32'd3,          32'h0000_0400, 32'd7,         1};
    vecs[3]  = '{EXE_OR,  FUN_SRL, 32'h8000_0000, 32'd4,          32'h0000_0400, 32'hF800_0000, 5};
    vecs[4]  = '{EXE_OR,  FUN_SRL, 32'h8000_0000, 32'd4,          32'h0,         32'h0800_0000, 5};
    vecs[5]  = '{EXE_ORI, FUN_SLLI,32'h1234_5678, 32'h0,          32'h0,         32'h1234_5678, 1};
    vecs[6]  = '{EXE_ORI, FUN_SLLI,32'h8000_0001, 32'h0,          32'h1,         32'h0000_0002, 2};
    vecs[7]  = '{EXE_OR,  FUN_SLL, 32'h1,         32'd31,         32'h0,         32'h8000_0000, 32};
    vecs[8]  = '{EXE_ORI, FUN_SRLI,32'h8000_0000, 32'h0,          32'h0000_041F, 32'hFFFF_FFFF, 32};
    vecs[9]  = '{8'h01,   FUN_ADD, 32'h0000_F0F0, 32'h0000_0FF0,  32'h0,         32'h0000_FF00, 1};
    vecs[10] = '{EXE_OR,  FUN_SLL, 32'd3,         32'h0000_0025,  32'h0,         32'h0000_0060, 6};

    rst = 1'b0; id_valid_i = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b1;
    drive_op('0, '0, '0, '0, '0, '0);
    #12;
    chk("reset_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_id_ready", 32'(id_ready_o), 32'd0);
    chk("reset_wdata", wdata_o, 32'd0);
    chk("reset_alu_wreg", 32'(alu_wreg_o), 32'd0);
    chk("reset_alu_reg1", alu_reg1_o, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_op(vecs[i], i);

    // Backpressure: three ADDs while MEM stalls, then release.
    got.delete();
    mem_ready_i = 1'b0;
    drive_op(EXE_OR, FUN_ADD, 32'd1, 32'd0, 32'd0, 5'd1); id_valid_i = 1'b1;
    @(posedge clk); #1;
    drive_op(EXE_OR, FUN_ADD, 32'd2, 32'd0, 32'd0, 5'd2);
    @(posedge clk); #1;
    drive_op(EXE_OR, FUN_ADD, 32'd3, 32'd0, 32'd0, 5'd3);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_mem_valid", 32'(mem_valid_o), 32'd1);
    chk("bp_wdata_held", wdata_o, 32'd1);
    chk("bp_id_ready", 32'(id_ready_o), 32'd0);
    chk("bp_busy", 32'(busy_o), 32'd1);
    chk("bp_nothing_drained", 32'(got.size()), 32'd0);
    mem_ready_i = 1'b1; #1;
    chk("bp_id_ready_release", 32'(id_ready_o), 32'd1);
    @(posedge clk); #1;
    id_valid_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("bp_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_order[%0d]", i), (i < got.size()) ? got[i] : 32'hxxxx_xxxx, 32'(i + 1));

    // Flush mid-shift while the output register holds a committed result.
    got.delete();
    mem_ready_i = 1'b0;
    drive_op(EXE_ORI, FUN_ORI, 32'hAAAA_AAAA, 32'd0, 32'd0, 5'd7); id_valid_i = 1'b1;
    @(posedge clk); #1;
    id_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("fl_held_valid", 32'(mem_valid_o), 32'd1);
    drive_op(EXE_OR, FUN_SLL, 32'd1, 32'd10, 32'd0, 5'd8); id_valid_i = 1'b1;
    @(posedge clk); #1;
    id_valid_i = 1'b0;
    chk("fl_shift_busy", 32'(busy_o), 32'd1);
    chk("fl_shift_id_ready", 32'(id_ready_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("fl_idle", 32'(busy_o), 32'd0);
    chk("fl_alu_wreg", 32'(alu_wreg_o), 32'd0);
    chk("fl_out_valid", 32'(mem_valid_o), 32'd1);
    chk("fl_out_wdata", wdata_o, 32'hAAAA_AAAA);
    mem_ready_i = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    chk("fl_count", 32'(got.size()), 32'd1);
    chk("fl_value", (got.size() > 0) ? got[0] : 32'hxxxx_xxxx, 32'hAAAA_AAAA);

    // Async reset mid-shift with a result sitting in the output register.
    got.delete();
    mem_ready_i = 1'b0;
    drive_op(EXE_ORI, FUN_ORI, 32'h55, 32'd0, 32'd0, 5'd9); id_valid_i = 1'b1;
    @(posedge clk); #1;
    id_valid_i = 1'b0;
    @(posedge clk); #1;
    drive_op(EXE_OR, FUN_SRL, 32'hF000_0000, 32'd20, 32'd0, 5'd10); id_valid_i = 1'b1;
    @(posedge clk); #1;
    id_valid_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rs_pre_busy", 32'(busy_o), 32'd1);
    chk("rs_pre_valid", 32'(mem_valid_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rs_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rs_busy", 32'(busy_o), 32'd0);
    chk("rs_id_ready", 32'(id_ready_o), 32'd0);
    @(negedge clk); rst = 1'b1; mem_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("rs_no_partial", 32'(got.size()), 32'd0);
    begin
      vec_t v;
      v = '{EXE_ORI, FUN_ORI, 32'h0000_0100, 32'h0, 32'h0000_0003, 32'h0000_0103, 1};
      run_op(v, 20);
    end
    chk("rs_after_count", 32'(got.size()), 32'd1);
    chk("rs_after_value", (got.size() > 0) ? got[0] : 32'hxxxx_xxxx, 32'h0000_0103);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_seq.md
Name: ex_seq

Overview:
- EX-stage sequencer wrapping the combinational `ex` ALU.
- Accepts decoded ops from ID over a valid/ready handshake and holds them in an operand register that drives the ALU.
- Executes SLL/SRL/SRA shifts iteratively, 1 bit/cycle, using its own shift accumulator.
- Captures results into an EX/MEM output register with downstream backpressure and flush support.

Parameters:
- DW, 32, data width (RegBus / ImmBus)
- AW, 5, register address width (RegAddrBus)
- OPW, 8, aluop width (AluOpBus)
- FW, 3, alufun width (AluFunBus)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- id_valid_i  in  1  ID presents an op
- id_ready_o  out  1  sequencer accepts this cycle
- aluop_i  in  OPW  op class (EXE_ORI / EXE_OR / other)
- alufun_i  in  FW  funct3
- reg1_i  in  DW  operand 1
- reg2_i  in  DW  operand 2
- imm_i  in  DW  immediate; bit 10 selects arithmetic/sub
- wd_i  in  AW  destination register
- wreg_i  in  1  write-enable
- flush_i  in  1  kill uncommitted op
- alu_aluop_o, alu_alufun_o, alu_reg1_o, alu_reg2_o, alu_imm_o, alu_wd_o, alu_wreg_o  out  as inputs  operand register to ALU
- alu_wdata_i  in  DW  ALU result
- mem_valid_o  out  1  output register holds a result
- mem_ready_i  in  1  MEM consumes this cycle
- wd_o  out  AW  registered destination
- wreg_o  out  1  registered write-enable
- wdata_o  out  DW  registered result
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; operand reg, shift accumulator, count and output reg all 0.
  - mem_valid_o=0; id_ready_o forced 0 while rst=0.
- Shift decode:
  - aluop EXE_ORI with FUN_SLLI/FUN_SRLI: shamt=imm_i[4:0].
  - aluop EXE_OR with FUN_SLL/FUN_SRL: shamt=reg2_i[4:0].
  - Right shifts: imm_i[10]=1 gives arithmetic (sign fill); 0 gives logical.
- out_free = !mem_valid_o || mem_ready_i.
- States:
  - IDLE:
    - id_ready_o=1.
    - Accept (id_valid_i & id_ready_o): load operand reg.
    - Non-shift or shamt=0 → EXEC.
    - Shift with shamt>0 → SHIFT; acc=reg1_i, cnt=shamt.
  - EXEC:
    - Result is alu_wdata_i, or acc if the op came from SHIFT.
    - If out_free: capture wd/wreg/result into output reg and set mem_valid_o.
    - id_ready_o=out_free. On capture, a same-cycle accept reloads the operand reg and goes to EXEC/SHIFT as in IDLE; otherwise → IDLE.
    - If !out_free: hold, id_ready_o=0.
  - SHIFT:
    - id_ready_o=0. Each cycle acc shifts 1 bit in the decoded direction/fill; cnt decrements.
    - When cnt becomes 0 → EXEC with result=acc.
- Latency (no backpressure):
  - Accepted at edge N → mem_valid_o=1 from edge N+1.
  - Shift of shamt k → mem_valid_o=1 from edge N+1+k.
- Throughput: 1 op/cycle for non-shifts.
- Output reg: mem_valid_o cleared when mem_ready_i & !capture; stays set on simultaneous drain+capture.
- flush_i (sync):
  - Clears operand reg, acc and cnt; state→IDLE.
  - Blocks same-cycle accept and capture.
  - The output reg is not cleared: it is already committed.
- Operand reg drives alu_* continuously; alu_wreg_o=0 when empty.
- Non-EXE_ORI/EXE_OR ops pass through with the ALU result; the sequencer adds no decode for them.
- rst asserted mid-shift: immediate return to reset values; no partial result is emitted.

Decomposition:
- defines.v (existing shared header) provides:
  - EXE_ORI, EXE_OR, FUN_SLLI, FUN_SRLI, FUN_SLL, FUN_SRL codes.
  - Bus-width macros and RstEnable redefined for active-low.
- State encodings IDLE/EXEC/SHIFT: local to ex_seq.
- One natural sub-module: ex_shift_iter (acc, cnt, direction/fill, done flag).

Test Plan:
- ORI reg1=0x0000_00F0, imm=0x0F, mem_ready_i=1 → wdata_o=0x0000_00FF, mem_valid_o=1 one edge after accept; id_ready_o stays 1.
- Three back-to-back ADDs with mem_ready_i=0 for 3 cycles → first result held in output reg; second held in EXEC; id_ready_o=0. Releasing mem_ready_i → results 1..3 emitted in order, no loss or duplicate.
- SRL with imm[10]=1, reg1=0x8000_0000, reg2[4:0]=4 → busy_o for 4 SHIFT cycles; id_ready_o=0; wdata_o=0xF800_0000. Same with imm[10]=0 → 0x0800_0000.
- SLLI imm[4:0]=0, reg1=0x1234_5678 → no SHIFT cycles; wdata_o=0x1234_5678 one edge after accept.
- flush_i asserted in 2nd cycle of a 10-bit shift while the output reg holds 0xAAAA_AAAA → state IDLE next cycle; 0xAAAA_AAAA still delivered; shifted result never appears.
- rst pulled low mid-shift (between edges) → mem_valid_o, busy_o, id_ready_o go 0 immediately. After release, first accepted ORI completes normally.
